// File: rtl/beep_sequencer_pkg.sv
// Shared types and the pattern table for the buzzer gate sequencer.
// Phase lengths are counted in prescaler ticks; beep count includes the first beep.
package beep_pkg;

    localparam int MS_W = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]      count;
        logic [MS_W-1:0] on_t;
        logic [MS_W-1:0] off_t;
    } pattern_t;

    // 0: reel-stop click, 1: win triple-beep, 2: jackpot tone, 3: error burst
    function automatic pattern_t pat_lut(input logic [1:0] pat);
        pattern_t p;
        case (pat)
            2'd0:    p = '{count: 3'd1, on_t: MS_W'(50),   off_t: MS_W'(0)};
            2'd1:    p = '{count: 3'd3, on_t: MS_W'(100),  off_t: MS_W'(100)};
            2'd2:    p = '{count: 3'd1, on_t: MS_W'(1000), off_t: MS_W'(0)};
            default: p = '{count: 3'd5, on_t: MS_W'(50),   off_t: MS_W'(50)};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/beep_sequencer_if.sv
// Request/status bundle between the game controller (master) and the sequencer (slave).
interface beep_sequencer_if;
    import beep_pkg::*;

    logic       start;
    logic [1:0] pat;
    logic       stop;
    logic       bz_en;
    logic       busy;
    logic       done;

    modport master (
        output start, pat, stop,
        input  bz_en, busy, done
    );

    modport slave (
        input  start, pat, stop,
        output bz_en, busy, done
    );

endinterface

// File: rtl/beep_sequencer_tick_prescaler.sv
// Mod-TICK_DIV cycle counter producing a one-cycle tick on wrap.
// Clear has priority over enable so each phase starts from a fresh tick boundary.
module tick_prescaler #(
    parameter int TICK_DIV = 12000
) (
    input  logic i_ck,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = i_en && (r_cnt == LAST);
    assign o_tick = w_wrap;

    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/beep_sequencer.sv
// Turns a START pulse plus pattern code into a timed on/off buzzer gate.
// All outputs are registered from the next-state decode.
//
//   state  | meaning
//   S_IDLE | gate off, waiting for START (prescaler held clear)
//   S_ON   | gate on, counting on_t ticks of the current beep
//   S_OFF  | gate off, gap between beeps, counting off_t ticks
module beep_sequencer
    import beep_pkg::*;
#(
    parameter int TICK_DIV = 12000
) (
    input  logic              i_ck,
    input  logic              i_rst,
    beep_sequencer_if.slave   io_beep
);

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_beep_cnt, w_beep_nxt;
    logic [MS_W-1:0] r_tick_cnt, w_tick_nxt;
    logic [MS_W-1:0] r_on_t, w_on_nxt;
    logic [MS_W-1:0] r_off_t, w_off_nxt;
    logic            r_bz_en, r_busy, r_done;
    logic            w_done_nxt;
    logic            w_psc_clr;
    logic            w_psc_en;
    logic            w_tick;
    logic            w_phase_end;
    pattern_t        w_lut;

    assign w_lut       = pat_lut(io_beep.pat);
    assign w_psc_en    = (r_state != S_IDLE);
    assign w_phase_end = w_tick && (r_tick_cnt == MS_W'(1));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_psc (
        .i_ck   (i_ck),
        .i_rst  (i_rst),
        .i_clr  (w_psc_clr),
        .i_en   (w_psc_en),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_beep_nxt  = r_beep_cnt;
        w_tick_nxt  = r_tick_cnt;
        w_on_nxt    = r_on_t;
        w_off_nxt   = r_off_t;
        w_done_nxt  = 1'b0;
        w_psc_clr   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_psc_clr = 1'b1;
                if (io_beep.start) begin
                    w_on_nxt    = w_lut.on_t;
                    w_off_nxt   = w_lut.off_t;
                    w_beep_nxt  = w_lut.count - 3'd1;
                    w_tick_nxt  = w_lut.on_t;
                    w_state_nxt = S_ON;
                end
            end
            S_ON: begin
                if (w_phase_end) begin
                    w_psc_clr = 1'b1;
                    if (r_beep_cnt == 3'd0) begin
                        w_tick_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tick_nxt  = r_off_t;
                        w_state_nxt = S_OFF;
                    end
                end else if (w_tick) begin
                    w_tick_nxt = r_tick_cnt - MS_W'(1);
                end
            end
            S_OFF: begin
                if (w_phase_end) begin
                    w_psc_clr   = 1'b1;
                    w_beep_nxt  = r_beep_cnt - 3'd1;
                    w_tick_nxt  = r_on_t;
                    w_state_nxt = S_ON;
                end else if (w_tick) begin
                    w_tick_nxt = r_tick_cnt - MS_W'(1);
                end
            end
            default: begin
                w_psc_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort from any state; in IDLE this also blocks a coincident START.
        if (io_beep.stop) begin
            w_state_nxt = S_IDLE;
            w_beep_nxt  = '0;
            w_tick_nxt  = '0;
            w_done_nxt  = 1'b0;
            w_psc_clr   = 1'b1;
        end
    end

    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_beep_cnt <= '0;
            r_tick_cnt <= '0;
            r_on_t     <= '0;
            r_off_t    <= '0;
            r_bz_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beep_cnt <= w_beep_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_on_t     <= w_on_nxt;
            r_off_t    <= w_off_nxt;
            r_bz_en    <= (w_state_nxt == S_ON);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign io_beep.bz_en = r_bz_en;
    assign io_beep.busy  = r_busy;
    assign io_beep.done  = r_done;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with TICK_DIV=4 (one tick = 4 clocks).
// Short per-cycle behaviour is table driven; long pattern timings use segment checks.
module tb_beep_sequencer;
    import beep_pkg::*;

    localparam int TD = 4;

    logic ck  = 1'b0;
    logic rst = 1'b1;

    beep_sequencer_if bus ();

    beep_sequencer #(
        .TICK_DIV (TD)
    ) dut (
        .i_ck    (ck),
        .i_rst   (rst),
        .io_beep (bus.slave)
    );

    always #5 ck = ~ck;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic [1:0] pat;
        logic       stop;
        logic [2:0] exp;   // {bz_en, busy, done} after the edge
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    function automatic logic [2:0] outs();
        return {bus.bz_en, bus.busy, bus.done};
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: bz_en/busy/done got %b required %b", name, act, exp);
        end
    endtask

    // Holds for len cycles expecting a fixed gate/busy level and no DONE.
    task automatic seg(input string name, input logic exp_bz, input logic exp_busy, input int len);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < len; i++) begin
            if (outs() !== {exp_bz, exp_busy, 1'b0}) begin
                bad++;
                if (first < 0) first = i;
            end
            step();
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad cycles (first at offset %0d) required 0", name, bad, first);
        end
    endtask

    task automatic fire(input logic [1:0] pat);
        bus.start = 1'b1;
        bus.pat   = pat;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pat   = 2'd0;
        bus.stop  = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 3'b000};
        vecs[1]  = '{1'b1, 1'b1, 2'd1, 1'b0, 3'b000};
        vecs[2]  = '{1'b1, 1'b1, 2'd2, 1'b0, 3'b000};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 1'b1, 3'b000};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 3'b000};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 1'b0, 3'b110};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b110};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 3'b000};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b110};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 3'b000};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        vecs[13] = '{1'b1, 1'b1, 2'd2, 1'b0, 3'b000};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000};

        for (int i = 0; i < 15; i++) begin
            rst       = vecs[i].rst;
            bus.start = vecs[i].start;
            bus.pat   = vecs[i].pat;
            bus.stop  = vecs[i].stop;
            step();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step();
        chk("idle_after_vectors", outs(), 3'b000);

        // Click: 50 ticks on, then DONE.
        fire(2'd0);
        seg("p0_on", 1'b1, 1'b1, 50 * TD);
        chk("p0_done", outs(), 3'b001);
        step();
        chk("p0_done_pulse", outs(), 3'b000);

        // Triple beep: on/off/on/off/on, 100 ticks each.
        fire(2'd1);
        seg("p1_on1",  1'b1, 1'b1, 100 * TD);
        seg("p1_off1", 1'b0, 1'b1, 100 * TD);
        seg("p1_on2",  1'b1, 1'b1, 100 * TD);
        seg("p1_off2", 1'b0, 1'b1, 100 * TD);
        seg("p1_on3",  1'b1, 1'b1, 100 * TD);
        chk("p1_done", outs(), 3'b001);
        step();
        seg("p1_quiet", 1'b0, 1'b0, 50);

        // Jackpot tone with an ignored START PAT=3 at tone cycle 500.
        fire(2'd2);
        seg("p2_pre", 1'b1, 1'b1, 499);
        bus.start = 1'b1;
        bus.pat   = 2'd3;
        chk("p2_busy_at_500", outs(), 3'b110);
        step();
        bus.start = 1'b0;
        seg("p2_rest", 1'b1, 1'b1, 1000 * TD - 500);
        chk("p2_done", outs(), 3'b001);
        step();
        seg("p2_quiet", 1'b0, 1'b0, 20);

        // Error burst aborted mid second gap.
        fire(2'd3);
        seg("p3_on1",  1'b1, 1'b1, 50 * TD);
        seg("p3_off1", 1'b0, 1'b1, 50 * TD);
        seg("p3_on2",  1'b1, 1'b1, 50 * TD);
        seg("p3_off2a", 1'b0, 1'b1, 100);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("p3_stopped", outs(), 3'b000);
        seg("p3_no_done", 1'b0, 1'b0, 2000);

        // START in the DONE cycle launches a fresh sequence.
        fire(2'd0);
        seg("b2b_on1", 1'b1, 1'b1, 50 * TD);
        chk("b2b_done1", outs(), 3'b001);
        bus.start = 1'b1;
        bus.pat   = 2'd0;
        step();
        bus.start = 1'b0;
        seg("b2b_on2", 1'b1, 1'b1, 50 * TD);
        chk("b2b_done2", outs(), 3'b001);
        step();
        chk("b2b_idle", outs(), 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
